// File: rtl/task_launch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// task_launch_ctrl_pkg
// Shared definitions for the task launch controller: core-count and R0-width
// constants, fence encodings, FSM state encodings and fence decode helpers.
// -----------------------------------------------------------------------------
package task_launch_ctrl_pkg;

    // Range definitions shared by the scheduler and the launch controller
    localparam int TLC_CORES = 16;
    localparam int TLC_R0_W  = 16;
    localparam int TLC_CNT_W = 16;

    // Fence encodings: bit0 = acquire, bit1 = release
    typedef enum logic [1:0] {
        TLC_FENCE_NONE   = 2'b00,
        TLC_FENCE_ACQ    = 2'b01,
        TLC_FENCE_REL    = 2'b10,
        TLC_FENCE_ACQREL = 2'b11
    } tlc_fence_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_FIRE = 2'b10,
        ST_HOLD = 2'b11
    } tlc_state_e;

    // Acquire: launch only once every core in the system is idle
    function automatic logic fence_is_acq(input logic [1:0] fence);
        return fence[0];
    endfunction

    // Release: block later descriptors until this launch's cores return
    function automatic logic fence_is_rel(input logic [1:0] fence);
        return fence[1];
    endfunction

endpackage

// File: rtl/task_launch_ctrl_if.sv
// -----------------------------------------------------------------------------
// task_launch_ctrl_if
// Descriptor handshake between the scheduler's decode stage (master) and the
// launch controller (slave).
//   desc_valid      master->slave  descriptor offered
//   desc_ready      slave->master  accepted when valid && ready at a rising edge
//   desc_core_mask  master->slave  target cores
//   desc_init_r0    master->slave  R0 init value for the targeted cores
//   desc_fence      master->slave  fence mode (NONE/ACQ/REL/ACQREL)
// -----------------------------------------------------------------------------
interface task_launch_ctrl_if
    import task_launch_ctrl_pkg::*;
#(
    parameter int CORES = TLC_CORES,
    parameter int R0_W  = TLC_R0_W
);
    logic             desc_valid;
    logic             desc_ready;
    logic [CORES-1:0] desc_core_mask;
    logic [R0_W-1:0]  desc_init_r0;
    logic [1:0]       desc_fence;

    modport master (
        output desc_valid, desc_core_mask, desc_init_r0, desc_fence,
        input  desc_ready
    );

    modport slave (
        input  desc_valid, desc_core_mask, desc_init_r0, desc_fence,
        output desc_ready
    );
endinterface

// File: rtl/task_launch_ctrl_core_busy_tracker.sv
// -----------------------------------------------------------------------------
// task_launch_ctrl_core_busy_tracker
// Per-core busy tracking. A launched core is busy until it has been seen to
// drop Ready at least once and then raise it again.
//   clk          system clock
//   reset        synchronous active-low reset
//   i_set_mask   cores being launched this edge (busy set, seen_low cleared)
//   i_core_ready per-core idle flag
//   o_busy_mask  cores launched and not yet returned
// -----------------------------------------------------------------------------
module task_launch_ctrl_core_busy_tracker
    import task_launch_ctrl_pkg::*;
#(
    parameter int CORES = TLC_CORES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CORES-1:0] i_set_mask,
    input  logic [CORES-1:0] i_core_ready,
    output logic [CORES-1:0] o_busy_mask
);

    genvar gi;
    generate
        for (gi = 0; gi < CORES; gi++) begin : g_core
            logic r_busy;
            logic r_seen_low;

            // Ready is still high right after launch, so it only counts as a
            // return once a low phase has been observed in between.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_busy     <= 1'b0;
                    r_seen_low <= 1'b0;
                end else if (i_set_mask[gi]) begin
                    r_busy     <= 1'b1;
                    r_seen_low <= 1'b0;
                end else if (r_busy) begin
                    if (!i_core_ready[gi]) begin
                        r_seen_low <= 1'b1;
                    end else if (r_seen_low) begin
                        r_busy     <= 1'b0;
                        r_seen_low <= 1'b0;
                    end
                end
            end

            assign o_busy_mask[gi] = r_busy;
        end
    endgenerate

endmodule

// File: rtl/task_launch_ctrl.sv
// -----------------------------------------------------------------------------
// task_launch_ctrl
// Accepts one decoded task descriptor at a time, waits until the targeted
// cores are free and the fence rule is met, issues a one-cycle start pulse
// with the R0 init value, and tracks busy cores until they return to Ready.
//   clk           system clock
//   reset         synchronous active-low reset
//   desc          descriptor handshake (slave side)
//   core_ready    per-core idle flag
//   start         one-cycle launch pulse per core
//   init_r0_vect  cores whose R0 is written this cycle (same as start)
//   init_r0       R0 value, qualified by init_r0_vect; holds after launch
//   busy_mask     cores launched and not yet returned
//   launch_count  completed launches, wrapping
//   err_empty     one-cycle pulse when a zero-mask descriptor is consumed
// -----------------------------------------------------------------------------
module task_launch_ctrl
    import task_launch_ctrl_pkg::*;
#(
    parameter int CORES = TLC_CORES,
    parameter int R0_W  = TLC_R0_W,
    parameter int CNT_W = TLC_CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    task_launch_ctrl_if.slave  desc,
    input  logic [CORES-1:0]   core_ready,
    output logic [CORES-1:0]   start,
    output logic [CORES-1:0]   init_r0_vect,
    output logic [R0_W-1:0]    init_r0,
    output logic [CORES-1:0]   busy_mask,
    output logic [CNT_W-1:0]   launch_count,
    output logic               err_empty
);

    tlc_state_e       r_state;
    tlc_state_e       w_state_next;
    logic             r_run;
    logic [CORES-1:0] r_mask;
    logic [R0_W-1:0]  r_r0;
    logic [1:0]       r_fence;
    logic [CORES-1:0] r_start;
    logic [R0_W-1:0]  r_init_r0;
    logic [CNT_W-1:0] r_count;
    logic             r_err;

    logic             w_desc_ready;
    logic             w_accept;
    logic             w_go_cond;
    logic             w_go;
    logic             w_err_next;
    logic             w_count_inc;
    logic [CORES-1:0] w_set_mask;
    logic [CORES-1:0] w_busy;

    // r_run holds off acceptance until the first edge after reset release,
    // so a descriptor held valid across reset is never taken during reset.
    assign w_desc_ready    = (r_state == ST_IDLE) && r_run;
    assign desc.desc_ready = w_desc_ready;
    assign w_accept        = desc.desc_valid && w_desc_ready;

    // Uses the pre-edge busy mask: a core returning this cycle launches next.
    assign w_go_cond = ((core_ready & r_mask) == r_mask) &&
                       ((w_busy & r_mask) == '0) &&
                       (!fence_is_acq(r_fence) || (w_busy == '0));

    always_comb begin
        w_state_next = r_state;
        w_go         = 1'b0;
        w_err_next   = 1'b0;
        w_count_inc  = 1'b0;
        w_set_mask   = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (desc.desc_core_mask == '0) w_err_next   = 1'b1;
                    else                           w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_go_cond) begin
                    w_go         = 1'b1;
                    w_state_next = ST_FIRE;
                end
            end
            ST_FIRE: begin
                w_set_mask   = r_mask;
                w_count_inc  = 1'b1;
                w_state_next = fence_is_rel(r_fence) ? ST_HOLD : ST_IDLE;
            end
            ST_HOLD: begin
                if ((w_busy & r_mask) == '0) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_run     <= 1'b0;
            r_mask    <= '0;
            r_r0      <= '0;
            r_fence   <= TLC_FENCE_NONE;
            r_start   <= '0;
            r_init_r0 <= '0;
            r_count   <= '0;
            r_err     <= 1'b0;
        end else begin
            r_run <= 1'b1;
            r_err <= w_err_next;
            if (w_accept) begin
                r_mask  <= desc.desc_core_mask;
                r_r0    <= desc.desc_init_r0;
                r_fence <= desc.desc_fence;
            end
            // Start lasts exactly the FIRE cycle
            r_start <= w_go ? r_mask : '0;
            if (w_go) r_init_r0 <= r_r0;
            if (w_count_inc) r_count <= r_count + 1'b1;
        end
    end

    task_launch_ctrl_core_busy_tracker #(
        .CORES (CORES)
    ) u_busy (
        .clk          (clk),
        .reset        (reset),
        .i_set_mask   (w_set_mask),
        .i_core_ready (core_ready),
        .o_busy_mask  (w_busy)
    );

    assign start        = r_start;
    assign init_r0_vect = r_start;
    assign init_r0      = r_init_r0;
    assign busy_mask    = w_busy;
    assign launch_count = r_count;
    assign err_empty    = r_err;

endmodule

// File: tb/tb_task_launch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_task_launch_ctrl
// Directed bench for task_launch_ctrl. Inputs change 1 time unit after each
// rising edge; outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_task_launch_ctrl;
    import task_launch_ctrl_pkg::*;

    logic        clk;
    logic        reset;
    logic [15:0] core_ready;
    logic [15:0] start;
    logic [15:0] init_r0_vect;
    logic [15:0] init_r0;
    logic [15:0] busy_mask;
    logic [15:0] launch_count;
    logic        err_empty;

    int checks = 0;
    int errors = 0;

    task_launch_ctrl_if #(.CORES(16), .R0_W(16)) dif ();

    task_launch_ctrl #(.CORES(16), .R0_W(16), .CNT_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .desc         (dif),
        .core_ready   (core_ready),
        .start        (start),
        .init_r0_vect (init_r0_vect),
        .init_r0      (init_r0),
        .busy_mask    (busy_mask),
        .launch_count (launch_count),
        .err_empty    (err_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
            $display("check %-16s observed=%h expected=%h ok", tag, obs, exp);
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset held 3 cycles with a descriptor already offered
        reset              = 1'b0;
        core_ready         = 16'hFFFF;
        dif.desc_valid     = 1'b1;
        dif.desc_core_mask = 16'hAAAA;
        dif.desc_init_r0   = 16'hABCD;
        dif.desc_fence     = TLC_FENCE_NONE;
        repeat (3) tick();
        chk("rst_ready", 32'(dif.desc_ready), 32'd0);
        chk("rst_start", 32'(start), 32'h0);
        chk("rst_vect", 32'(init_r0_vect), 32'h0);
        chk("rst_r0", 32'(init_r0), 32'h0);
        chk("rst_busy", 32'(busy_mask), 32'h0);
        chk("rst_count", 32'(launch_count), 32'h0);
        chk("rst_err", 32'(err_empty), 32'h0);

        reset = 1'b1;
        chk("rel_ready_same", 32'(dif.desc_ready), 32'd0);
        tick();
        chk("rel_ready_next", 32'(dif.desc_ready), 32'd1);

        // Launch 1: AAAA, fence NONE
        tick();                                   // accept edge
        dif.desc_valid = 1'b0;
        chk("l1_acc_ready", 32'(dif.desc_ready), 32'd0);
        chk("l1_acc_start", 32'(start), 32'h0);
        tick();                                   // start set
        chk("l1_start", 32'(start), 32'hAAAA);
        chk("l1_vect", 32'(init_r0_vect), 32'hAAAA);
        chk("l1_r0", 32'(init_r0), 32'hABCD);
        chk("l1_busy_pre", 32'(busy_mask), 32'h0);
        chk("l1_count_pre", 32'(launch_count), 32'h0);
        tick();                                   // FIRE ends
        chk("l1_start_clr", 32'(start), 32'h0);
        chk("l1_vect_clr", 32'(init_r0_vect), 32'h0);
        chk("l1_busy", 32'(busy_mask), 32'hAAAA);
        chk("l1_count", 32'(launch_count), 32'h1);
        chk("l1_r0_hold", 32'(init_r0), 32'hABCD);
        chk("l1_ready", 32'(dif.desc_ready), 32'd1);

        // Launch 2: 0002 blocked until core 1 returns
        core_ready         = 16'h5555;
        dif.desc_valid     = 1'b1;
        dif.desc_core_mask = 16'h0002;
        dif.desc_init_r0   = 16'h1234;
        dif.desc_fence     = TLC_FENCE_NONE;
        for (int i = 0; i < 4; i++) begin
            tick();
            dif.desc_valid = 1'b0;
            chk("l2_blocked", 32'(start), 32'h0);
            chk("l2_ready", 32'(dif.desc_ready), 32'd0);
        end
        core_ready = 16'hFFFF;
        tick();                                   // busy clears, no launch yet
        chk("l2_busy_clr", 32'(busy_mask), 32'h0);
        chk("l2_late", 32'(start), 32'h0);
        tick();
        chk("l2_start", 32'(start), 32'h0002);
        chk("l2_r0", 32'(init_r0), 32'h1234);
        tick();
        chk("l2_busy", 32'(busy_mask), 32'h0002);
        chk("l2_count", 32'(launch_count), 32'h2);

        // Launch 3: 0001 with REL, then 0100 waits for core 0 to return
        core_ready         = 16'hFFFD;            // core 1 drops Ready
        dif.desc_valid     = 1'b1;
        dif.desc_core_mask = 16'h0001;
        dif.desc_init_r0   = 16'h5555;
        dif.desc_fence     = TLC_FENCE_REL;
        tick();                                   // accept REL
        core_ready         = 16'hFFFF;
        dif.desc_core_mask = 16'h0100;
        dif.desc_init_r0   = 16'h0BEE;
        dif.desc_fence     = TLC_FENCE_NONE;
        chk("rel_acc_ready", 32'(dif.desc_ready), 32'd0);
        tick();
        chk("rel_start", 32'(start), 32'h0001);
        chk("rel_core1_ret", 32'(busy_mask), 32'h0);
        tick();
        chk("rel_busy", 32'(busy_mask), 32'h0001);
        chk("rel_count", 32'(launch_count), 32'h3);
        chk("rel_hold0", 32'(dif.desc_ready), 32'd0);
        repeat (2) begin
            tick();
            chk("rel_hold", 32'(dif.desc_ready), 32'd0);
        end
        core_ready = 16'hFFFE;
        tick();
        chk("rel_hold_low", 32'(dif.desc_ready), 32'd0);
        core_ready = 16'hFFFF;
        tick();                                   // core 0 returns
        chk("rel_busy_clr", 32'(busy_mask), 32'h0);
        chk("rel_hold_last", 32'(dif.desc_ready), 32'd0);
        tick();
        chk("rel_released", 32'(dif.desc_ready), 32'd1);
        chk("rel_no_start", 32'(start), 32'h0);
        tick();                                   // accept 0100
        dif.desc_valid = 1'b0;
        tick();
        chk("l4_start", 32'(start), 32'h0100);
        chk("l4_r0", 32'(init_r0), 32'h0BEE);
        tick();
        chk("l4_busy", 32'(busy_mask), 32'h0100);
        chk("l4_count", 32'(launch_count), 32'h4);

        // Launch 5: 00F0, core 8 returns meanwhile; then ACQ 0F00 queued
        core_ready         = 16'hFEFF;
        dif.desc_valid     = 1'b1;
        dif.desc_core_mask = 16'h00F0;
        dif.desc_init_r0   = 16'h00F0;
        dif.desc_fence     = TLC_FENCE_NONE;
        tick();                                   // accept 00F0
        core_ready         = 16'hFFFF;
        dif.desc_core_mask = 16'h0F00;
        dif.desc_init_r0   = 16'h0F0F;
        dif.desc_fence     = TLC_FENCE_ACQ;
        tick();
        chk("l5_start", 32'(start), 32'h00F0);
        chk("l5_core8_ret", 32'(busy_mask), 32'h0);
        tick();
        chk("l5_busy", 32'(busy_mask), 32'h00F0);
        chk("l5_count", 32'(launch_count), 32'h5);
        chk("l5_ready", 32'(dif.desc_ready), 32'd1);
        tick();                                   // accept ACQ 0F00
        dif.desc_valid = 1'b0;
        repeat (2) begin
            tick();
            chk("acq_blocked", 32'(start), 32'h0);
        end
        core_ready = 16'hFF0F;
        tick();
        chk("acq_blocked_low", 32'(start), 32'h0);
        core_ready = 16'hFFFF;
        tick();                                   // busy reaches 0
        chk("acq_busy_clr", 32'(busy_mask), 32'h0);
        chk("acq_late", 32'(start), 32'h0);
        tick();
        chk("acq_start", 32'(start), 32'h0F00);
        chk("acq_r0", 32'(init_r0), 32'h0F0F);
        tick();
        chk("acq_busy", 32'(busy_mask), 32'h0F00);
        chk("acq_count", 32'(launch_count), 32'h6);

        // Empty descriptor
        dif.desc_valid     = 1'b1;
        dif.desc_core_mask = 16'h0000;
        dif.desc_init_r0   = 16'hDEAD;
        dif.desc_fence     = TLC_FENCE_NONE;
        tick();
        dif.desc_valid = 1'b0;
        chk("emp_err", 32'(err_empty), 32'd1);
        chk("emp_start", 32'(start), 32'h0);
        chk("emp_ready", 32'(dif.desc_ready), 32'd1);
        chk("emp_count", 32'(launch_count), 32'h6);
        tick();
        chk("emp_err_clr", 32'(err_empty), 32'd0);
        chk("emp_start2", 32'(start), 32'h0);
        chk("emp_count2", 32'(launch_count), 32'h6);
        chk("emp_busy", 32'(busy_mask), 32'h0F00);

        // Reset during FIRE
        dif.desc_valid     = 1'b1;
        dif.desc_core_mask = 16'h0003;
        dif.desc_init_r0   = 16'h3333;
        tick();                                   // accept
        dif.desc_valid = 1'b0;
        tick();
        chk("frst_start", 32'(start), 32'h0003);
        reset = 1'b0;
        tick();
        chk("frst_start_clr", 32'(start), 32'h0);
        chk("frst_vect_clr", 32'(init_r0_vect), 32'h0);
        chk("frst_busy", 32'(busy_mask), 32'h0);
        chk("frst_count", 32'(launch_count), 32'h0);
        chk("frst_r0", 32'(init_r0), 32'h0);
        reset = 1'b1;
        tick();
        tick();
        chk("frst_ready", 32'(dif.desc_ready), 32'd1);
        chk("frst_busy2", 32'(busy_mask), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
